// File: rtl/modport_slave_if.sv
// modport_slave_if: ICB-style command/response bus between a master and the
// modport_slave register block.
//   cmd channel: icb_cmd_valid/ready, addr, read, wdata, wmask (master -> slave)
//   rsp channel: icb_rsp_valid/ready, rdata, err              (slave -> master)
interface modport_slave_if;
  logic        icb_cmd_valid;
  logic        icb_cmd_ready;
  logic [63:0] icb_cmd_addr;
  logic        icb_cmd_read;
  logic [63:0] icb_cmd_wdata;
  logic [7:0]  icb_cmd_wmask;
  logic        icb_rsp_valid;
  logic        icb_rsp_ready;
  logic [63:0] icb_rsp_rdata;
  logic        icb_rsp_err;

  modport slave (
    input  icb_cmd_valid,
    output icb_cmd_ready,
    input  icb_cmd_addr,
    input  icb_cmd_read,
    input  icb_cmd_wdata,
    input  icb_cmd_wmask,
    output icb_rsp_valid,
    input  icb_rsp_ready,
    output icb_rsp_rdata,
    output icb_rsp_err
  );

  modport master (
    output icb_cmd_valid,
    input  icb_cmd_ready,
    output icb_cmd_addr,
    output icb_cmd_read,
    output icb_cmd_wdata,
    output icb_cmd_wmask,
    input  icb_rsp_valid,
    output icb_rsp_ready,
    input  icb_rsp_rdata,
    input  icb_rsp_err
  );
endinterface

// File: rtl/modport_slave.sv
// modport_slave: 8 x 64-bit register window on an ICB-style bus.
//   R0..R6 read/write with byte enables, R7 read-only (ID_VALUE).
//   One-cycle response latency, one response outstanding at most,
//   back-to-back throughput of one command per cycle.
// Ports:
//   clk   - clock, rising edge
//   rst_n - synchronous reset, asserted HIGH (name kept for compatibility)
//   bus   - modport_slave_if.slave, command and response channels
module modport_slave #(
  parameter logic [63:0] BASE_ADDR = 64'h0000_0000_1000_0000,
  parameter logic [63:0] ID_VALUE  = 64'h4943_4253_4C56_0001
) (
  input  logic          clk,
  input  logic          rst_n,
  modport_slave_if.slave bus
);

  logic [63:0] regs [0:6];
  logic        rsp_valid;
  logic [63:0] rsp_rdata;
  logic        rsp_err;

  logic        cmd_accept;
  logic        hit;
  logic [2:0]  idx;
  logic        cmd_err;
  logic        wr_en;
  logic [63:0] rd_val;

  // A pending response frees the slot on the same edge it is consumed.
  assign bus.icb_cmd_ready = ~rst_n & (~rsp_valid | bus.icb_rsp_ready);
  assign cmd_accept        = bus.icb_cmd_valid & bus.icb_cmd_ready;

  assign bus.icb_rsp_valid = rsp_valid;
  assign bus.icb_rsp_rdata = rsp_rdata;
  assign bus.icb_rsp_err   = rsp_err;

  always_comb begin
    hit     = (bus.icb_cmd_addr[63:6] == BASE_ADDR[63:6]) &&
              (bus.icb_cmd_addr[2:0] == 3'b000);
    idx     = bus.icb_cmd_addr[5:3];
    // R7 is read-only: a write to it is an error, not a silent drop.
    cmd_err = ~hit | (~bus.icb_cmd_read & (idx == 3'd7));
    wr_en   = cmd_accept & ~bus.icb_cmd_read & ~cmd_err;
    rd_val  = ID_VALUE;
    case (idx)
      3'd0:    rd_val = regs[0];
      3'd1:    rd_val = regs[1];
      3'd2:    rd_val = regs[2];
      3'd3:    rd_val = regs[3];
      3'd4:    rd_val = regs[4];
      3'd5:    rd_val = regs[5];
      3'd6:    rd_val = regs[6];
      default: rd_val = ID_VALUE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      rsp_valid <= 1'b0;
      rsp_rdata <= 64'h0;
      rsp_err   <= 1'b0;
      for (int k = 0; k < 7; k++) regs[k] <= 64'h0;
    end else begin
      if (cmd_accept) begin
        rsp_valid <= 1'b1;
        rsp_err   <= cmd_err;
        rsp_rdata <= (bus.icb_cmd_read && !cmd_err) ? rd_val : 64'h0;
      end else if (rsp_valid && bus.icb_rsp_ready) begin
        rsp_valid <= 1'b0;
      end

      for (int k = 0; k < 7; k++) begin
        if (wr_en && (idx == k[2:0])) begin
          for (int b = 0; b < 8; b++) begin
            if (bus.icb_cmd_wmask[b])
              regs[k][8*b +: 8] <= bus.icb_cmd_wdata[8*b +: 8];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_modport_slave.sv
module tb_modport_slave;

  localparam logic [63:0] B  = 64'h0000_0000_1000_0000;
  localparam logic [63:0] ID = 64'h4943_4253_4C56_0001;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  modport_slave_if bus();

  modport_slave #(.BASE_ADDR(B), .ID_VALUE(ID)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rd;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [7:0]  wmask;
    logic [63:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rd, input logic [63:0] addr, input logic [63:0] wdata,
                     input logic [7:0] wmask, input logic [63:0] exp_rdata, input logic exp_err);
    vec_t v;
    v.rd = rd; v.addr = addr; v.wdata = wdata; v.wmask = wmask;
    v.exp_rdata = exp_rdata; v.exp_err = exp_err;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic issue(input logic rd, input logic [63:0] addr, input logic [63:0] wdata,
                       input logic [7:0] wmask);
    bus.icb_cmd_valid = 1'b1;
    bus.icb_cmd_read  = rd;
    bus.icb_cmd_addr  = addr;
    bus.icb_cmd_wdata = wdata;
    bus.icb_cmd_wmask = wmask;
  endtask

  // Single command, rsp_ready high: response must be visible after one edge.
  task automatic run_one(input string name, input vec_t v);
    @(negedge clk);
    chk({name, " idle"}, {63'h0, bus.icb_rsp_valid}, 64'h0);
    bus.icb_rsp_ready = 1'b1;
    issue(v.rd, v.addr, v.wdata, v.wmask);
    chk({name, " cmd_ready"}, {63'h0, bus.icb_cmd_ready}, 64'h1);
    @(posedge clk);
    @(negedge clk);
    bus.icb_cmd_valid = 1'b0;
    chk({name, " rsp_valid"}, {63'h0, bus.icb_rsp_valid}, 64'h1);
    chk({name, " rdata"}, bus.icb_rsp_rdata, v.exp_rdata);
    chk({name, " err"}, {63'h0, bus.icb_rsp_err}, {63'h0, v.exp_err});
  endtask

  logic [63:0] held;
  logic [63:0] b2b_addr [4];
  logic [63:0] b2b_exp  [4];

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n = 1'b1;
    bus.icb_cmd_valid = 1'b0;
    bus.icb_cmd_read  = 1'b0;
    bus.icb_cmd_addr  = 64'h0;
    bus.icb_cmd_wdata = 64'h0;
    bus.icb_cmd_wmask = 8'h0;
    bus.icb_rsp_ready = 1'b0;

    // rd, addr, wdata, wmask, exp_rdata, exp_err
    add(0, B + 64'h08, 64'h1122_3344_5566_7788, 8'hFF, 64'h0, 0);
    add(1, B + 64'h08, 64'h0, 8'h00, 64'h1122_3344_5566_7788, 0);
    add(0, B + 64'h10, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 64'h0, 0);
    add(0, B + 64'h10, 64'h0, 8'h0F, 64'h0, 0);
    add(1, B + 64'h10, 64'h0, 8'h00, 64'hFFFF_FFFF_0000_0000, 0);
    add(1, B + 64'h38, 64'h0, 8'h00, ID, 0);
    add(0, B + 64'h38, 64'h1234, 8'hFF, 64'h0, 1);
    add(1, B + 64'h38, 64'h0, 8'h00, ID, 0);
    add(1, B + 64'h40, 64'h0, 8'h00, 64'h0, 1);
    add(1, B + 64'h04, 64'h0, 8'h00, 64'h0, 1);
    add(0, B + 64'h04, 64'hAAAA_AAAA_AAAA_AAAA, 8'hFF, 64'h0, 1);
    add(1, B + 64'h00, 64'h0, 8'h00, 64'h0, 0);
    add(0, B + 64'h00, 64'hAAAA_AAAA_AAAA_AAAA, 8'h00, 64'h0, 0);
    add(1, B + 64'h00, 64'h0, 8'h00, 64'h0, 0);
    add(0, B + 64'h1000, 64'h5555, 8'hFF, 64'h0, 1);
    add(0, B + 64'h28, 64'h1122_3344_5566_7788, 8'h81, 64'h0, 0);
    add(1, B + 64'h28, 64'hDEAD_DEAD_DEAD_DEAD, 8'hFF, 64'h1100_0000_0000_0088, 0);
    add(0, B + 64'h30, 64'hDEAD_BEEF_CAFE_F00D, 8'h3C, 64'h0, 0);
    add(1, B + 64'h30, 64'h0, 8'h00, 64'h0000_BEEF_CAFE_0000, 0);
    add(1, B + 64'h08, 64'h0, 8'h00, 64'h1122_3344_5566_7788, 0);

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset rsp_valid", {63'h0, bus.icb_rsp_valid}, 64'h0);
    chk("reset cmd_ready", {63'h0, bus.icb_cmd_ready}, 64'h0);
    chk("reset rdata", bus.icb_rsp_rdata, 64'h0);
    chk("reset err", {63'h0, bus.icb_rsp_err}, 64'h0);
    rst_n = 1'b0;

    foreach (vecs[i]) run_one($sformatf("vec%0d", i), vecs[i]);

    // Response stall: rsp_ready low for 3 cycles after a read.
    @(negedge clk);
    bus.icb_rsp_ready = 1'b0;
    issue(1, B + 64'h08, 64'h0, 8'h00);
    @(posedge clk);
    @(negedge clk);
    bus.icb_cmd_valid = 1'b0;
    held = bus.icb_rsp_rdata;
    chk("stall first rdata", held, 64'h1122_3344_5566_7788);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("stall%0d rsp_valid", c), {63'h0, bus.icb_rsp_valid}, 64'h1);
      chk($sformatf("stall%0d rdata", c), bus.icb_rsp_rdata, 64'h1122_3344_5566_7788);
      chk($sformatf("stall%0d cmd_ready", c), {63'h0, bus.icb_cmd_ready}, 64'h0);
    end
    bus.icb_rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("stall drained", {63'h0, bus.icb_rsp_valid}, 64'h0);

    // Back-to-back: 4 reads, cmd_valid held, done after 5 edges.
    b2b_addr[0] = B + 64'h08; b2b_exp[0] = 64'h1122_3344_5566_7788;
    b2b_addr[1] = B + 64'h10; b2b_exp[1] = 64'hFFFF_FFFF_0000_0000;
    b2b_addr[2] = B + 64'h38; b2b_exp[2] = ID;
    b2b_addr[3] = B + 64'h28; b2b_exp[3] = 64'h1100_0000_0000_0088;
    for (int i = 0; i < 4; i++) begin
      issue(1, b2b_addr[i], 64'h0, 8'h00);
      chk($sformatf("b2b%0d cmd_ready", i), {63'h0, bus.icb_cmd_ready}, 64'h1);
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("b2b%0d rsp_valid", i), {63'h0, bus.icb_rsp_valid}, 64'h1);
      chk($sformatf("b2b%0d rdata", i), bus.icb_rsp_rdata, b2b_exp[i]);
    end
    bus.icb_cmd_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("b2b done at edge 5", {63'h0, bus.icb_rsp_valid}, 64'h0);

    // Reset while a write response is pending.
    bus.icb_rsp_ready = 1'b0;
    issue(0, B + 64'h18, 64'h55, 8'hFF);
    @(posedge clk);
    @(negedge clk);
    bus.icb_cmd_valid = 1'b0;
    chk("pend rsp_valid", {63'h0, bus.icb_rsp_valid}, 64'h1);
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("midreset rsp_valid", {63'h0, bus.icb_rsp_valid}, 64'h0);
    chk("midreset cmd_ready", {63'h0, bus.icb_cmd_ready}, 64'h0);
    rst_n = 1'b0;
    begin
      vec_t v;
      v.rd = 1; v.addr = B + 64'h18; v.wdata = 64'h0; v.wmask = 8'h0;
      v.exp_rdata = 64'h0; v.exp_err = 0;
      run_one("post-reset R3", v);
      v.addr = B + 64'h08;
      run_one("post-reset R1", v);
    end

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/modport_slave.md
MODPORT_SLAVE -- requirements
Module: modport_slave

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 64'h0000_0000_1000_0000, base byte address of the register window.
REQ-002 SHALL have parameter ID_VALUE, default 64'h4943_4253_4C56_0001, constant returned by register 7.
REQ-003 SHALL have port clk  input  1  single clock, all logic on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous and active-high (asserted when 1, despite the _n suffix).
REQ-005 SHALL have port icb_cmd_valid  input  1  command request from master.
REQ-006 SHALL have port icb_cmd_ready  output  1  slave can accept a command.
REQ-007 SHALL have port icb_cmd_addr  input  64  byte address.
REQ-008 SHALL have port icb_cmd_read  input  1  1=read, 0=write.
REQ-009 SHALL have port icb_cmd_wdata  input  64  write data.
REQ-010 SHALL have port icb_cmd_wmask  input  8  byte-enable, bit i enables wdata[8i+7:8i].
REQ-011 SHALL have port icb_rsp_valid  output  1  response available.
REQ-012 SHALL have port icb_rsp_ready  input  1  master accepts response.
REQ-013 SHALL have port icb_rsp_rdata  output  64  read data (0 for writes and errors).
REQ-014 SHALL have port icb_rsp_err  output  1  response error flag.

Function
REQ-015 SHALL contain 8 x 64-bit registers R0..R7 at BASE_ADDR + 8*k; R0..R6 read/write, R7 read-only returning ID_VALUE.
REQ-016 SHALL accept a command on a clk edge where icb_cmd_valid & icb_cmd_ready (cmd handshake).
REQ-017 SHALL drive icb_cmd_ready = ~icb_rsp_valid | icb_rsp_ready (combinational), so at most one response is outstanding.
REQ-018 SHALL assert icb_rsp_valid on the edge after a cmd handshake (1-cycle latency), with rdata/err registered on that same edge.
REQ-019 SHALL hold icb_rsp_valid, icb_rsp_rdata and icb_rsp_err stable until the edge where icb_rsp_valid & icb_rsp_ready.
REQ-020 SHALL clear icb_rsp_valid on a response handshake unless a new command is accepted on the same edge, in which case the new response is loaded and icb_rsp_valid stays 1 (back-to-back throughput 1 per cycle).
REQ-021 SHALL decode as hit when icb_cmd_addr[63:6] == BASE_ADDR[63:6] and icb_cmd_addr[2:0] == 0; index = icb_cmd_addr[5:3].
REQ-022 SHALL, on a write hit to R0..R6, update only the bytes enabled by icb_cmd_wmask on the handshake edge; response err=0, rdata=0.
REQ-023 SHALL treat a write with icb_cmd_wmask = 0 as a successful no-op (err=0).
REQ-024 SHALL, on a read hit, return the register value as sampled at the handshake edge (before any same-edge write, which cannot occur given one command per edge), err=0.
REQ-025 SHALL respond err=1, rdata=0, with no state change, for: address outside window, misaligned address, or write to R7.
REQ-026 SHALL ignore icb_cmd_wdata and icb_cmd_wmask on reads.
REQ-027 SHALL never drop or reorder responses; each accepted command produces exactly one response.

Reset
REQ-028 SHALL, while rst_n=1 on a clk edge, set R0..R6 = 0, icb_rsp_valid = 0, icb_rsp_rdata = 0, icb_rsp_err = 0.
REQ-029 SHALL drive icb_cmd_ready = 0 while rst_n=1.
REQ-030 SHALL discard any pending response and in-flight command when reset is asserted mid-transaction.

Verification
REQ-031 Write R1 (BASE+0x08) wdata 64'h1122_3344_5566_7788 wmask 8'hFF, then read BASE+0x08 -> write rsp err=0; read rsp rdata 64'h1122_3344_5566_7788 err=0, each rsp_valid one cycle after accept.
REQ-032 Write R2=64'hFFFF_FFFF_FFFF_FFFF mask FF, then write 64'h0 mask 8'h0F, read R2 -> rdata 64'hFFFF_FFFF_0000_0000.
REQ-033 Read BASE+0x38 -> rdata ID_VALUE err=0; write BASE+0x38 -> err=1, subsequent read still ID_VALUE.
REQ-034 Read BASE+0x40 and BASE+0x04 -> err=1, rdata 0, no register changes.
REQ-035 Hold icb_rsp_ready=0 for 3 cycles after a read -> rsp_valid/rdata stable, cmd_ready=0; with rsp_ready=1 and cmd_valid continuous, 4 back-to-back reads complete in 5 cycles.
REQ-036 Assert rst_n=1 while a response is pending after writing R3=64'h55 -> rsp_valid=0 next edge; read R3 after reset -> rdata 0.
